// File: rtl/vram_cmd_sched.sv
// Display command decoder and single-port VRAM arbiter.
// Scanout reads always win the port; command writes use the remaining cycles.
module vram_cmd_sched #(
  parameter int         ADDR_W     = 16,
  parameter logic [7:0] OP_SETADDR = 8'h01,
  parameter logic [7:0] OP_WRITE   = 8'h02,
  parameter logic [7:0] OP_FILL    = 8'h03
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [7:0]        cmd_data,
  output logic              cmd_ready,
  input  logic              scan_req,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic              scan_grant,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_wdata,
  output logic              vram_we,
  output logic              vram_re,
  output logic              busy,
  output logic              cmd_err
);

  typedef enum logic [3:0] {
    S_OP,
    S_ALO,
    S_AHI,
    S_WDATA,
    S_WAIT,
    S_FCLO,
    S_FCHI,
    S_FDATA,
    S_FILL
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [7:0]        data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic              grant_q, grant_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic fire;
  logic pend;

  assign fire = cmd_valid && ready_q;
  assign pend = (state_q == S_WAIT) || (state_q == S_FILL);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    grant_d = 1'b0;
    err_d   = 1'b0;

    if (scan_req) begin
      re_d    = 1'b1;
      grant_d = 1'b1;
      addr_d  = scan_addr;
    end else if (pend) begin
      we_d    = 1'b1;
      addr_d  = ptr_q;
      wdata_d = data_q;
      ptr_d   = ptr_q + ADDR_W'(1);
      if (state_q == S_WAIT) begin
        state_d = S_OP;
      end else begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_q == 16'd1) state_d = S_OP;
      end
    end

    // pend and fire are mutually exclusive: ready is low while a write waits
    if (fire) begin
      case (state_q)
        S_OP: begin
          unique case (1'b1)
            (cmd_data == OP_SETADDR): state_d = S_ALO;
            (cmd_data == OP_WRITE):   state_d = S_WDATA;
            (cmd_data == OP_FILL):    state_d = S_FCLO;
            default:                  err_d   = 1'b1;
          endcase
        end
        S_ALO: begin
          ptr_d[7:0] = cmd_data;
          state_d    = S_AHI;
        end
        S_AHI: begin
          ptr_d   = {cmd_data[ADDR_W-9:0], ptr_q[7:0]};
          state_d = S_OP;
        end
        S_WDATA: begin
          data_d  = cmd_data;
          state_d = S_WAIT;
        end
        S_FCLO: begin
          cnt_d[7:0] = cmd_data;
          state_d    = S_FCHI;
        end
        S_FCHI: begin
          cnt_d[15:8] = cmd_data;
          state_d     = S_FDATA;
        end
        S_FDATA: begin
          data_d  = cmd_data;
          state_d = (cnt_q == 16'd0) ? S_OP : S_FILL;
        end
        default: ;
      endcase
    end

    ready_d = (state_d != S_WAIT) && (state_d != S_FILL);
    busy_d  = (state_d != S_OP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_OP;
      ptr_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      grant_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      re_q    <= re_d;
      grant_q <= grant_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready  = ready_q;
  assign scan_grant = grant_q;
  assign vram_addr  = addr_q;
  assign vram_wdata = wdata_q;
  assign vram_we    = we_q;
  assign vram_re    = re_q;
  assign busy       = busy_q;
  assign cmd_err    = err_q;

endmodule

// File: tb/tb_vram_cmd_sched.sv
// Directed per-cycle vector bench for vram_cmd_sched.
// Each row: inputs before an edge, expected registered outputs after it.
module tb_vram_cmd_sched;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic [7:0]  cmd_data;
  logic        cmd_ready;
  logic        scan_req;
  logic [15:0] scan_addr;
  logic        scan_grant;
  logic [15:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic        vram_we;
  logic        vram_re;
  logic        busy;
  logic        cmd_err;

  vram_cmd_sched dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_data   (cmd_data),
    .cmd_ready  (cmd_ready),
    .scan_req   (scan_req),
    .scan_addr  (scan_addr),
    .scan_grant (scan_grant),
    .vram_addr  (vram_addr),
    .vram_wdata (vram_wdata),
    .vram_we    (vram_we),
    .vram_re    (vram_re),
    .busy       (busy),
    .cmd_err    (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        val;
    logic [7:0]  dat;
    logic        sr;
    logic [15:0] sa;
    logic        rdy;
    logic        gnt;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic        we;
    logic        re;
    logic        bsy;
    logic        err;
  } vec_t;

  vec_t vq[$];
  int   n_cmp;
  int   n_err;

  task automatic add(input logic r, input logic v, input logic [7:0] d,
                     input logic sr, input logic [15:0] sa,
                     input logic rdy, input logic gnt,
                     input logic [15:0] a, input logic [7:0] wd,
                     input logic we, input logic re,
                     input logic bsy, input logic err);
    vec_t e;
    e.rst = r; e.val = v; e.dat = d; e.sr = sr; e.sa = sa;
    e.rdy = rdy; e.gnt = gnt; e.addr = a; e.wd = wd;
    e.we = we; e.re = re; e.bsy = bsy; e.err = err;
    vq.push_back(e);
  endtask

  task automatic chk(input string nm, input int row,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d,
                      input logic sr, input logic [15:0] sa);
    rst = 1'b0; cmd_valid = v; cmd_data = d;
    scan_req = sr; scan_addr = sa;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit seen;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_data = 8'h00;
    scan_req = 1'b0; scan_addr = 16'h0000;

    // r v  dat   sr sa        rdy gnt addr      wd   we re bsy err
    add(1,0,8'h00,0,16'h0000, 0,0,16'h0000,8'h00,0,0,0,0);
    add(0,0,8'h00,0,16'h0000, 1,0,16'h0000,8'h00,0,0,0,0);
    add(0,1,8'h01,0,16'h0000, 1,0,16'h0000,8'h00,0,0,1,0);
    add(0,1,8'h34,0,16'h0000, 1,0,16'h0000,8'h00,0,0,1,0);
    add(0,1,8'h12,0,16'h0000, 1,0,16'h0000,8'h00,0,0,0,0);
    add(0,1,8'h02,0,16'h0000, 1,0,16'h0000,8'h00,0,0,1,0);
    add(0,1,8'hAB,0,16'h0000, 0,0,16'h0000,8'h00,0,0,1,0);
    add(0,0,8'h00,0,16'h0000, 1,0,16'h1234,8'hAB,1,0,0,0);
    add(0,1,8'h7F,0,16'h0000, 1,0,16'h1234,8'hAB,0,0,0,1);
    add(0,1,8'h02,0,16'h0000, 1,0,16'h1234,8'hAB,0,0,1,0);
    add(0,1,8'hCC,0,16'h0000, 0,0,16'h1234,8'hAB,0,0,1,0);
    add(0,0,8'h00,0,16'h0000, 1,0,16'h1235,8'hCC,1,0,0,0);
    add(0,0,8'h00,0,16'h0000, 1,0,16'h1235,8'hCC,0,0,0,0);
    add(0,1,8'h01,0,16'h0000, 1,0,16'h1235,8'hCC,0,0,1,0);
    add(0,1,8'h00,0,16'h0000, 1,0,16'h1235,8'hCC,0,0,1,0);
    add(0,1,8'h01,0,16'h0000, 1,0,16'h1235,8'hCC,0,0,0,0);
    add(0,1,8'h03,0,16'h0000, 1,0,16'h1235,8'hCC,0,0,1,0);
    add(0,1,8'h04,0,16'h0000, 1,0,16'h1235,8'hCC,0,0,1,0);
    add(0,1,8'h00,0,16'h0000, 1,0,16'h1235,8'hCC,0,0,1,0);
    add(0,1,8'h5A,0,16'h0000, 0,0,16'h1235,8'hCC,0,0,1,0);
    add(0,1,8'h7F,0,16'h0000, 0,0,16'h0100,8'h5A,1,0,1,0);
    add(0,1,8'h7F,1,16'h0777, 0,1,16'h0777,8'h5A,0,1,1,0);
    add(0,1,8'h7F,1,16'h0777, 0,1,16'h0777,8'h5A,0,1,1,0);
    add(0,1,8'h7F,1,16'h0777, 0,1,16'h0777,8'h5A,0,1,1,0);
    add(0,1,8'h7F,0,16'h0000, 0,0,16'h0101,8'h5A,1,0,1,0);
    add(0,1,8'h7F,0,16'h0000, 0,0,16'h0102,8'h5A,1,0,1,0);
    add(0,1,8'h7F,0,16'h0000, 1,0,16'h0103,8'h5A,1,0,0,0);
    add(0,0,8'h00,0,16'h0000, 1,0,16'h0103,8'h5A,0,0,0,0);
    add(0,1,8'h01,0,16'h0000, 1,0,16'h0103,8'h5A,0,0,1,0);
    add(0,1,8'hFE,0,16'h0000, 1,0,16'h0103,8'h5A,0,0,1,0);
    add(0,1,8'hFF,0,16'h0000, 1,0,16'h0103,8'h5A,0,0,0,0);
    add(0,1,8'h03,0,16'h0000, 1,0,16'h0103,8'h5A,0,0,1,0);
    add(0,1,8'h03,0,16'h0000, 1,0,16'h0103,8'h5A,0,0,1,0);
    add(0,1,8'h00,0,16'h0000, 1,0,16'h0103,8'h5A,0,0,1,0);
    add(0,1,8'h11,0,16'h0000, 0,0,16'h0103,8'h5A,0,0,1,0);
    add(0,0,8'h00,0,16'h0000, 0,0,16'hFFFE,8'h11,1,0,1,0);
    add(0,0,8'h00,0,16'h0000, 0,0,16'hFFFF,8'h11,1,0,1,0);
    add(0,0,8'h00,0,16'h0000, 1,0,16'h0000,8'h11,1,0,0,0);
    add(0,1,8'h03,0,16'h0000, 1,0,16'h0000,8'h11,0,0,1,0);
    add(0,1,8'h00,0,16'h0000, 1,0,16'h0000,8'h11,0,0,1,0);
    add(0,1,8'h00,0,16'h0000, 1,0,16'h0000,8'h11,0,0,1,0);
    add(0,1,8'h22,0,16'h0000, 1,0,16'h0000,8'h11,0,0,0,0);
    add(0,0,8'h00,0,16'h0000, 1,0,16'h0000,8'h11,0,0,0,0);
    add(0,1,8'h02,0,16'h0000, 1,0,16'h0000,8'h11,0,0,1,0);
    add(0,1,8'h33,0,16'h0000, 0,0,16'h0000,8'h11,0,0,1,0);
    add(0,0,8'h00,0,16'h0000, 1,0,16'h0001,8'h33,1,0,0,0);
    add(0,1,8'h01,0,16'h0000, 1,0,16'h0001,8'h33,0,0,1,0);
    add(0,1,8'h00,0,16'h0000, 1,0,16'h0001,8'h33,0,0,1,0);
    add(0,1,8'h20,0,16'h0000, 1,0,16'h0001,8'h33,0,0,0,0);
    add(0,1,8'h03,0,16'h0000, 1,0,16'h0001,8'h33,0,0,1,0);
    add(0,1,8'h0A,0,16'h0000, 1,0,16'h0001,8'h33,0,0,1,0);
    add(0,1,8'h00,0,16'h0000, 1,0,16'h0001,8'h33,0,0,1,0);
    add(0,1,8'h77,0,16'h0000, 0,0,16'h0001,8'h33,0,0,1,0);
    add(0,0,8'h00,0,16'h0000, 0,0,16'h2000,8'h77,1,0,1,0);
    add(0,0,8'h00,0,16'h0000, 0,0,16'h2001,8'h77,1,0,1,0);
    add(1,1,8'h01,1,16'h0555, 0,0,16'h0000,8'h00,0,0,0,0);
    add(0,0,8'h00,0,16'h0000, 1,0,16'h0000,8'h00,0,0,0,0);
    add(0,0,8'h00,0,16'h0000, 1,0,16'h0000,8'h00,0,0,0,0);
    add(0,1,8'h02,0,16'h0000, 1,0,16'h0000,8'h00,0,0,1,0);
    add(0,1,8'h44,0,16'h0000, 0,0,16'h0000,8'h00,0,0,1,0);
    add(0,0,8'h00,0,16'h0000, 1,0,16'h0000,8'h44,1,0,0,0);

    for (int i = 0; i < vq.size(); i++) begin
      rst = vq[i].rst; cmd_valid = vq[i].val; cmd_data = vq[i].dat;
      scan_req = vq[i].sr; scan_addr = vq[i].sa;
      @(posedge clk);
      #1;
      chk("cmd_ready", i, 32'(cmd_ready), 32'(vq[i].rdy));
      chk("scan_grant", i, 32'(scan_grant), 32'(vq[i].gnt));
      chk("vram_addr", i, 32'(vram_addr), 32'(vq[i].addr));
      chk("vram_wdata", i, 32'(vram_wdata), 32'(vq[i].wd));
      chk("vram_we", i, 32'(vram_we), 32'(vq[i].we));
      chk("vram_re", i, 32'(vram_re), 32'(vq[i].re));
      chk("busy", i, 32'(busy), 32'(vq[i].bsy));
      chk("cmd_err", i, 32'(cmd_err), 32'(vq[i].err));
      chk("re_we_excl", i, 32'(vram_re & vram_we), 32'd0);
    end

    // State is held in S_ALO while the host has nothing to send.
    step(1, 8'h01, 0, 16'h0000);
    for (int k = 0; k < 8; k++) begin
      step(0, 8'h00, 0, 16'h0000);
      chk("hold_busy", 100 + k, 32'(busy), 32'd1);
      chk("hold_ready", 100 + k, 32'(cmd_ready), 32'd1);
      chk("hold_we", 100 + k, 32'(vram_we), 32'd0);
    end
    step(1, 8'h00, 0, 16'h0000);
    step(1, 8'h30, 0, 16'h0000);
    chk("hold_setaddr_busy", 110, 32'(busy), 32'd0);

    // A pending write waits out continuous scanout traffic.
    step(1, 8'h02, 0, 16'h0000);
    step(1, 8'h66, 0, 16'h0000);
    chk("starve_ready", 120, 32'(cmd_ready), 32'd0);
    for (int k = 0; k < 6; k++) begin
      step(0, 8'h00, 1, 16'h0ABC);
      chk("starve_re", 130 + k, 32'(vram_re), 32'd1);
      chk("starve_we", 130 + k, 32'(vram_we), 32'd0);
      chk("starve_addr", 130 + k, 32'(vram_addr), 32'h0ABC);
      chk("starve_busy", 130 + k, 32'(busy), 32'd1);
    end
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(0, 8'h00, 0, 16'h0000);
      if (vram_we) begin
        seen = 1'b1;
        break;
      end
    end
    chk("starve_we_seen", 140, 32'(seen), 32'd1);
    chk("starve_wr_addr", 141, 32'(vram_addr), 32'h3000);
    chk("starve_wr_data", 142, 32'(vram_wdata), 32'h66);
    chk("starve_re_off", 143, 32'(vram_re), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vram_cmd_sched.md
Name: vram_cmd_sched

Overview:
- Sits between the host command FIFO read logic and a single-port video RAM.
- Decodes the display command byte stream: set address, write one byte, fill a run.
- Shares the one VRAM port between scanout reads from the pixel pipeline and command writes.
- Scanout has absolute priority, so the visible raster never stalls; command writes use idle cycles.

Parameters:
ADDR_W, 16, VRAM address width; the address pointer wraps modulo 2^ADDR_W
OP_SETADDR, 8'h01, opcode: next two bytes are address lo, hi
OP_WRITE, 8'h02, opcode: next byte is data, written at pointer, pointer++
OP_FILL, 8'h03, opcode: next bytes are count lo, count hi, data; writes count bytes from pointer, pointer++ each

Ports:
clk  in  1  system clock (PLL clock on global buffer)
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command byte available (latched disp_cmd_avail)
cmd_data  in  8  command byte
cmd_ready  out  1  byte consumed this cycle when cmd_valid && cmd_ready
scan_req  in  1  scanout read request for this cycle
scan_addr  in  ADDR_W  scanout read address
scan_grant  out  1  scanout read issued on VRAM port this cycle
vram_addr  out  ADDR_W  VRAM address (registered)
vram_wdata  out  8  VRAM write data (registered)
vram_we  out  1  VRAM write strobe, 1 cycle per byte
vram_re  out  1  VRAM read strobe, 1 cycle per read
busy  out  1  command executor not in S_OP
cmd_err  out  1  1-cycle pulse: unknown opcode dropped

Behaviour:
- Reset is synchronous, active-high, and mid-operation safe: it aborts any command immediately.
- Reset values: every output 0, pointer 0, state S_OP, fill count 0, no pending write.
- Reset has priority over all other inputs.
- Arbitration, sampled at each posedge, with outputs registered (1-cycle latency):
  - scan_req=1 -> next cycle vram_re=1, vram_addr=scan_addr, scan_grant=1, vram_we=0.
  - Else, if a write is pending -> next cycle vram_we=1, vram_addr=pointer, vram_wdata=data; the write is retired and pointer+1.
  - Else -> vram_re=vram_we=0; vram_addr and vram_wdata hold their values.
- vram_re and vram_we are never both 1.
- Starvation of writes under continuous scan_req is permitted.
- Executor states:
  - S_OP, S_ALO, S_AHI, S_WDATA, S_FCLO, S_FCHI, S_FDATA: accept one byte each; cmd_ready=1 only in these states and only when no write is pending.
  - S_WAIT: a single write is pending; cmd_ready=0.
  - S_FILL: a fill run is in progress; cmd_ready=0.
- Transitions:
  - S_OP: byte==OP_SETADDR -> S_ALO; OP_WRITE -> S_WDATA; OP_FILL -> S_FCLO.
  - S_OP, any other byte: consumed, cmd_err pulses for 1 cycle, stay in S_OP.
  - S_ALO: latch pointer[7:0] -> S_AHI.
  - S_AHI: latch pointer[ADDR_W-1:8] from byte[ADDR_W-9:0] (upper bits ignored) -> S_OP.
  - S_WDATA: latch data, write pending -> S_WAIT.
  - S_WAIT: when the write is retired -> S_OP.
  - S_FCLO, S_FCHI: latch count (16-bit, lo then hi).
  - S_FDATA: latch data. Count==0 -> S_OP with no write; else -> S_FILL.
  - S_FILL: a write is pending each cycle; each retired write decrements count. After the retire that takes count to 0 -> S_OP.
- Pointer arithmetic is modulo 2^ADDR_W. Write at 0xFFFF (ADDR_W=16) is followed by pointer 0x0000; a fill crossing the top wraps.
- busy=1 in every state except S_OP. busy deasserts the cycle after the last write is retired.
- cmd_ready is a registered output, valid the same cycle the state is.
- A byte is consumed only when cmd_valid && cmd_ready. With cmd_valid=0 the state is held indefinitely.

Test Plan:
- Reset then bytes 01 34 12 02 AB, scan_req=0 -> one vram_we pulse, addr 0x1234, wdata 0xAB; pointer ends 0x1235; busy low after the write.
- Fill: 01 00 01, then 03 04 00 5A -> four consecutive vram_we pulses, addrs 0x0100..0x0103, data 0x5A; cmd_ready=0 throughout the fill.
- Priority: during the fill, hold scan_req=1 for 3 cycles with scan_addr=0x0777 -> 3 read cycles, scan_grant=1, no we. The fill resumes at the correct next address; total 4 writes.
- Wrap and zero count: set addr 0xFFFE, fill count 3 data 0x11 -> writes at 0xFFFE, 0xFFFF, 0x0000. Then fill count 0 -> no writes, immediately back to S_OP.
- Bad opcode 0x7F -> cmd_err one-cycle pulse, no VRAM access; the following 02 CC writes 0xCC at the current pointer.
- Assert rst mid-fill (2 of 10 writes done) -> next cycle all outputs 0, state S_OP, pointer 0; no further writes.
